// File: rtl/reg_dump_reader.sv
// Walks a register bank's combinational read port from address 0 to the top and
// streams each snapshotted word out on a valid/ready interface with its address.
module reg_dump_reader #(
    parameter int N      = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [N-1:0]      rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [N-1:0]      out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;
    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              out_valid_q;
    logic [N-1:0]      out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_last_q;
    logic              busy_q;
    logic              done_q;

    assign rd_addr_d = rd_addr_q + ONE;

    // All outputs are registered; out_last is cleared on leaving HOLD so it is
    // only ever high alongside out_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    out_data_q  <= rd_data_i;
                    out_addr_q  <= rd_addr_q;
                    out_last_q  <= (rd_addr_q == MAX_ADDR);
                    out_valid_q <= 1'b1;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rd_addr_q <= rd_addr_d;
                            state_q   <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    rd_addr_q <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr_o   = rd_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_addr_o  = out_addr_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: each accepted start queues the whole bank
// image in address order; a negedge monitor pops and compares on every handshake.
module tb_reg_dump_reader;
    localparam int N     = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic [AW-1:0] rd_addr, out_addr;
    logic [N-1:0]  rd_data, out_data;
    logic          out_valid, out_last, busy, done;
    logic [N-1:0]  bank [DEPTH];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    exp_done = 1'b0;
    bit    model_busy = 1'b0;

    reg_dump_reader #(.N(N), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rd_addr_o(rd_addr),
        .rd_data_i(rd_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_addr_o(out_addr), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
    );

    assign rd_data = bank[rd_addr];
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: done must appear exactly one cycle after the last word's handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_done) begin
                chk("done_pulse", done, 1);
                exp_done   = 1'b0;
                model_busy = 1'b0;
            end else begin
                chk("done_spurious", done, 0);
            end
            chk("done_with_valid", done & out_valid, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_addr", out_addr, w.addr);
                    chk("word_data", out_data, w.data);
                    chk("word_last", out_last, (int'(w.addr) == DEPTH - 1));
                    if (int'(w.addr) == DEPTH - 1) exp_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        word_t w;
        start = 1'b1;
        if (!model_busy) begin
            for (int i = 0; i < DEPTH; i++) begin
                w.addr = AW'(i);
                w.data = bank[i];
                exp_q.push_back(w);
            end
            model_busy = 1'b1;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic flush_model();
        exp_q.delete();
        model_busy = 1'b0;
        exp_done   = 1'b0;
    endtask

    // Runs until the model sees done; optionally randomizes ready and pokes start.
    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (model_busy && n < 300) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                start     = ($urandom_range(0, 7) == 0);
            end
            tick();
            start = 1'b0;
            n++;
        end
        if (model_busy) begin
            chk("timeout", 1, 0);
            flush_model();
        end
    endtask

    task automatic load_pattern();
        for (int i = 0; i < DEPTH; i++) bank[i] = N'(8'h10 + 8'h11 * i);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        load_pattern();
        tick(); tick();
        chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);       chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_data", out_data, 0); chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        rst = 1'b0;
        tick();

        // Basic dump with latency checks
        out_ready = 1'b1;
        start_dump();
        chk("lat_busy", busy, 1);
        chk("lat_valid_read", out_valid, 0);
        tick();
        chk("lat_valid_hold", out_valid, 1);
        chk("lat_first_addr", out_addr, 0);
        wait_idle(1'b0);
        chk("basic_busy_after", busy, 0);
        chk("basic_q_empty", exp_q.size(), 0);

        // Backpressure on word 2, bank word changes underneath
        start_dump();
        for (int n = 0; n < 20; n++) begin
            if (out_valid && out_addr == 2) break;
            tick();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h32);
            if (k == 1) bank[2] = 8'hFF;
        end
        out_ready = 1'b1;
        wait_idle(1'b0);
        bank[2] = 8'h32;

        // Start while busy is ignored
        start_dump();
        for (int n = 0; n < 20; n++) begin
            if (out_valid && out_addr == 4) break;
            tick();
        end
        start_dump();
        wait_idle(1'b0);
        chk("busy_start_q_empty", exp_q.size(), 0);
        repeat (3) tick();
        chk("busy_start_no_restart", busy, 0);

        // Reset in HOLD of word 5
        out_ready = 1'b0;
        start_dump();
        for (int n = 0; n < 40; n++) begin
            tick();
            if (out_valid) begin
                if (out_addr == 5) break;
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
        chk("pre_rst_addr5", out_addr, 5);
        rst = 1'b1;
        flush_model();
        tick();
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0); chk("midrst_busy", busy, 0);
        chk("midrst_rd_addr", rd_addr, 0); chk("midrst_done", done, 0);
        repeat (3) tick();
        out_ready = 1'b1;
        start_dump();
        wait_idle(1'b0);

        // start and rst together
        start = 1'b1; rst = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        chk("strst_busy", busy, 0); chk("strst_valid", out_valid, 0);
        tick();
        chk("strst_busy2", busy, 0);
        start_dump();
        wait_idle(1'b0);

        // Idle stability
        for (int k = 0; k < 20; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            chk("idle_valid", out_valid, 0); chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);       chk("idle_rd_addr", rd_addr, 0);
        end

        // Randomized dumps
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) bank[i] = N'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            start_dump();
            wait_idle(1'b1);
            chk("rnd_q_empty", exp_q.size(), 0);
            repeat (2) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
